// File: rtl/bcd_display_pkg.sv
// ---------------------------------------------------------------------------
// bcd_display_pkg
// Shared definitions for the BCD display encoder:
//   state_t            - controller state encoding (IDLE, CONV, FMT, HOLD)
//   DEFAULT_BLANK_CODE - nibble driven for a blanked leading-zero digit
//   max_bcd_value()    - largest value representable in n decimal digits
// ---------------------------------------------------------------------------
package bcd_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_FMT  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam logic [3:0] DEFAULT_BLANK_CODE = 4'hF;

    // Returns 10^n_digits - 1. Only evaluated at elaboration time; the x10
    // step is written as shift-and-add so no multiplier is ever implied.
    function automatic longint unsigned max_bcd_value(input int unsigned n_digits);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < n_digits; i++) begin
            p = (p << 3) + (p << 1);
        end
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/bcd_display_encoder_add3.sv
// ---------------------------------------------------------------------------
// bcd_add3
// Per-digit double-dabble correction: adds 3 to a BCD digit of 5 or more so
// that the following left shift carries correctly into the next digit.
// Ports:
//   din  - 4-bit BCD digit before correction
//   dout - 4-bit corrected digit
// ---------------------------------------------------------------------------
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/bcd_display_encoder.sv
// ---------------------------------------------------------------------------
// bcd_display_encoder
// Converts an unsigned binary count into N_DIGITS BCD digits using a
// sequential double-dabble (one input bit per cycle), then formats the
// result with optional leading-zero blanking or an overflow pattern.
// Ports:
//   clk       - sole clock, rising edge
//   rst_n     - synchronous active-low reset
//   in_valid  - in_value/blank_en offered
//   in_ready  - block can accept a new value (IDLE only)
//   in_value  - unsigned binary value to display
//   blank_en  - request leading-zero blanking for this value
//   out_valid - disp/ovf hold a finished result
//   out_ready - consumer takes the result
//   disp      - BCD digits, digit 0 in bits [3:0]
//   ovf       - value exceeded 10^N_DIGITS-1
// ---------------------------------------------------------------------------
module bcd_display_encoder
    import bcd_display_pkg::*;
#(
    parameter int                      IN_W        = 14,
    parameter int                      N_DIGITS    = 4,
    parameter logic [4*N_DIGITS-1:0]   OVF_PATTERN = 16'hABCD,
    parameter logic [3:0]              BLANK_CODE  = DEFAULT_BLANK_CODE
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_W-1:0]         in_value,
    input  logic                    blank_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*N_DIGITS-1:0]   disp,
    output logic                    ovf
);

    localparam int              DW      = 4 * N_DIGITS;
    localparam int              CNT_W   = $clog2(IN_W);
    localparam longint unsigned MAX_VAL = max_bcd_value(N_DIGITS);
    localparam longint unsigned IN_MAX  = (IN_W >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                       : ((64'd1 << IN_W) - 64'd1);
    // When every IN_W-bit value fits in N_DIGITS digits, overflow can never
    // happen and the comparator is not built.
    localparam bit              OVF_POSSIBLE = (MAX_VAL < IN_MAX);

    state_t             state;
    state_t             state_nxt;
    logic [IN_W-1:0]    bin_sr;
    logic [DW-1:0]      bcd_sr;
    logic [DW-1:0]      bcd_adj;
    logic [DW-1:0]      bcd_shifted;
    logic [DW-1:0]      disp_fmt;
    logic [DW-1:0]      bcd_blanked;
    logic [CNT_W-1:0]   bit_cnt;
    logic               blank_q;
    logic               ovf_q;
    logic               ovf_cmp;
    logic               conv_last;
    logic               leading;

    assign in_ready  = (state == ST_IDLE) && rst_n;
    assign out_valid = (state == ST_HOLD);
    assign conv_last = (bit_cnt == CNT_W'(IN_W - 1));

    // Overflow compare against 10^N_DIGITS-1, only when it can ever fire.
    generate
        if (OVF_POSSIBLE) begin : g_ovf
            localparam logic [IN_W-1:0] MAX_W = MAX_VAL[IN_W-1:0];
            assign ovf_cmp = (in_value > MAX_W);
        end else begin : g_no_ovf
            assign ovf_cmp = 1'b0;
        end
    endgenerate

    // One add-3 corrector per digit; the corrected vector is then shifted
    // left with the next binary MSB entering digit 0.
    generate
        for (genvar g = 0; g < N_DIGITS; g++) begin : g_add3
            bcd_add3 u_add3 (
                .din  (bcd_sr[4*g +: 4]),
                .dout (bcd_adj[4*g +: 4])
            );
        end
    endgenerate

    assign bcd_shifted = {bcd_adj[DW-2:0], bin_sr[IN_W-1]};

    // Leading-zero blanking: walk down from the top digit, replacing zeros
    // until the first non-zero digit. Digit 0 is never visited, so a value of
    // zero still shows a single 0.
    always_comb begin
        bcd_blanked = bcd_sr;
        leading     = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            if (leading && (bcd_sr[4*i +: 4] == 4'd0)) begin
                bcd_blanked[4*i +: 4] = BLANK_CODE;
            end else begin
                leading = 1'b0;
            end
        end
    end

    always_comb begin
        disp_fmt = bcd_sr;
        if (ovf_q) begin
            disp_fmt = OVF_PATTERN;
        end else if (blank_q) begin
            disp_fmt = bcd_blanked;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. HOLD returns to IDLE on the handshake edge, so a new
    // value can only be accepted one cycle later.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid)  state_nxt = ST_CONV;
            ST_CONV: if (conv_last) state_nxt = ST_FMT;
            ST_FMT:                 state_nxt = ST_HOLD;
            ST_HOLD: if (out_ready) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: capture on accept, shift during CONV, publish in FMT.
    // disp/ovf keep the previous result until the next FMT cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_sr  <= '0;
            bcd_sr  <= '0;
            bit_cnt <= '0;
            blank_q <= 1'b0;
            ovf_q   <= 1'b0;
            disp    <= '0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        bin_sr  <= in_value;
                        bcd_sr  <= '0;
                        bit_cnt <= '0;
                        blank_q <= blank_en;
                        ovf_q   <= ovf_cmp;
                    end
                end
                ST_CONV: begin
                    bcd_sr  <= bcd_shifted;
                    bin_sr  <= {bin_sr[IN_W-2:0], 1'b0};
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
                ST_FMT: begin
                    disp <= disp_fmt;
                    ovf  <= ovf_q;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_display_encoder.sv
// ---------------------------------------------------------------------------
// tb_bcd_display_encoder
// Scoreboard bench: stimulus pushes hand-computed expected results into a
// queue, an independent monitor pops and compares each time out_valid rises,
// including the accept-to-valid latency.
// ---------------------------------------------------------------------------
module tb_bcd_display_encoder;

    localparam int IN_W    = 14;
    localparam int LATENCY = IN_W + 1;

    typedef struct {
        logic [15:0] disp;
        logic        ovf;
        int unsigned val;
    } exp_t;

    typedef struct {
        logic [13:0] val;
        logic        blank;
        logic [15:0] disp;
        logic        ovf;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] in_value;
    logic        blank_en;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] disp;
    logic        ovf;

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    logic        ov_prev = 1'b0;
    exp_t        exp_q[$];
    int          acc_q[$];

    bcd_display_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .blank_en  (blank_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .disp      (disp),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparison helper shared by stimulus and monitor.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Records the cycle number of every accept edge; an abort by reset
    // discards accepts that will never produce a result.
    always @(posedge clk) begin
        if (!rst_n) begin
            acc_q.delete();
        end else if (in_valid && in_ready) begin
            acc_q.push_back(cyc);
        end
        cyc++;
    end

    // Monitor: compares each newly presented result with the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        int   lat;
        if (rst_n && out_valid && !ov_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_result: got disp=%h ovf=%0d, expected no result",
                         disp, ovf);
            end else begin
                e = exp_q.pop_front();
                checkOutput($sformatf("disp(%0d)", e.val), {16'h0, disp}, {16'h0, e.disp});
                checkOutput($sformatf("ovf(%0d)", e.val), {31'h0, ovf}, {31'h0, e.ovf});
                if (acc_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL latency(%0d): got no accept edge, expected one", e.val);
                end else begin
                    lat = cyc - acc_q.pop_front() - 1;
                    checkOutput($sformatf("latency(%0d)", e.val), lat, LATENCY);
                end
            end
        end
        ov_prev = out_valid;
    end

    // Offers one value until accepted, then scrambles the inputs so a design
    // that keeps reading them after accept would be caught.
    task automatic applyStimulus(input logic [13:0] v, input logic b,
                                 input logic [15:0] ed, input logic eo,
                                 input bit expect_result);
        exp_t e;
        bit   done;
        done = 1'b0;
        if (expect_result) begin
            e.disp = ed;
            e.ovf  = eo;
            e.val  = v;
            exp_q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_value = v;
        blank_en = b;
        for (int i = 0; i < 100 && !done; i++) begin
            if (in_ready) begin
                @(posedge clk);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout(%0d): got in_ready=0, expected 1", v);
        end
        #1;
        in_valid = 1'b0;
        in_value = ~v;
        blank_en = ~b;
    endtask

    task automatic waitIdle(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready && !out_valid) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_timeout(%s): got in_ready=%0d out_valid=%0d, expected 1/0",
                     name, in_ready, out_valid);
        end
    endtask

    task automatic waitValid(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (out_valid) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL valid_timeout(%s): got out_valid=0, expected 1", name);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[$];

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_value  = '0;
        blank_en  = 1'b0;
        out_ready = 1'b1;

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("reset_in_ready",  {31'h0, in_ready},  32'h0);
        checkOutput("reset_out_valid", {31'h0, out_valid}, 32'h0);
        checkOutput("reset_disp",      {16'h0, disp},      32'h0);
        checkOutput("reset_ovf",       {31'h0, ovf},       32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("release_in_ready", {31'h0, in_ready}, 32'h1);

        // Directed vectors with hand-computed expectations.
        vecs.push_back('{14'd1234,  1'b0, 16'h1234, 1'b0});
        vecs.push_back('{14'd7,     1'b1, 16'hFFF7, 1'b0});
        vecs.push_back('{14'd0,     1'b1, 16'hFFF0, 1'b0});
        vecs.push_back('{14'd9999,  1'b0, 16'h9999, 1'b0});
        vecs.push_back('{14'd10000, 1'b1, 16'hABCD, 1'b1});
        vecs.push_back('{14'd50,    1'b1, 16'hFF50, 1'b0});
        vecs.push_back('{14'd1005,  1'b1, 16'h1005, 1'b0});
        vecs.push_back('{14'd9,     1'b0, 16'h0009, 1'b0});
        foreach (vecs[k]) begin
            applyStimulus(vecs[k].val, vecs[k].blank, vecs[k].disp, vecs[k].ovf, 1'b1);
            waitIdle($sformatf("vec%0d", k));
        end

        // Consumer stalls in HOLD while another value is offered.
        out_ready = 1'b0;
        applyStimulus(14'd321, 1'b0, 16'h0321, 1'b0, 1'b1);
        waitValid("stall");
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_value = 14'd42;
            blank_en = 1'b0;
            @(negedge clk);
            checkOutput($sformatf("stall_disp%0d", i),      {16'h0, disp},      32'h0321);
            checkOutput($sformatf("stall_in_ready%0d", i),  {31'h0, in_ready},  32'h0);
            checkOutput($sformatf("stall_out_valid%0d", i), {31'h0, out_valid}, 32'h1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("release_out_valid", {31'h0, out_valid}, 32'h0);
        checkOutput("release_in_ready2", {31'h0, in_ready},  32'h1);
        checkOutput("retain_disp",       {16'h0, disp},      32'h0321);
        checkOutput("no_reaccept",       acc_q.size(),       32'h0);

        // Reset in the middle of a conversion aborts it silently.
        applyStimulus(14'd1234, 1'b0, 16'h0000, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort_out_valid", {31'h0, out_valid}, 32'h0);
        checkOutput("abort_disp",      {16'h0, disp},      32'h0);
        checkOutput("abort_ovf",       {31'h0, ovf},       32'h0);
        checkOutput("abort_in_ready",  {31'h0, in_ready},  32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort_release_in_ready", {31'h0, in_ready}, 32'h1);
        repeat (25) @(negedge clk);
        checkOutput("abort_no_result", {31'h0, out_valid}, 32'h0);

        // Back-to-back conversions with the consumer always ready.
        applyStimulus(14'd16383, 1'b0, 16'hABCD, 1'b1, 1'b1);
        applyStimulus(14'd1,     1'b0, 16'h0001, 1'b0, 1'b1);
        waitIdle("b2b");

        repeat (3) @(negedge clk);
        checkOutput("pending_results", exp_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
